systolic_wave_seq: RTL and testbench

Wavefront sequencer for the N×N systolic MAC array. On a start pulse it drives skewed read strobes and addresses into the per-row activation RAMs and per-column weight RAMs, and per-PE MAC-enable/accumulator-clear strobes, so that inner-product step s reaches PE(i,j) on the correct diagonal cycle. It sits between the top-level array controller (which issues start and length) and the array/operand RAMs, and reports completion with a one-cycle done pulse.

---
 rtl/systolic_pkg.sv | 14 +
 rtl/systolic_wave_cell.sv | 28 ++
 rtl/systolic_wave_seq.sv | 150 +++++++++++++++
 tb/tb_systolic_wave_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and default geometry for the systolic wavefront sequencer.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int SEQ_N      = 2;
  localparam int SEQ_ADDR_W = 8;
  localparam int SEQ_K_W    = 9;

endpackage

// File: rtl/systolic_wave_cell.sv
// Per-PE strobe decode: MAC enable on the PE's diagonal window, accumulator clear on its first step.
module systolic_wave_cell
  import systolic_pkg::*;
#(
  parameter int          K_W    = SEQ_K_W,
  parameter int unsigned OFFSET = 0
) (
  input  logic [K_W:0]   t,
  input  logic [K_W-1:0] k,
  input  logic           gate,
  output logic           en_mac,
  output logic           clr_accum
);

  localparam int TW = K_W + 2;

  logic [TW-1:0] t_w;
  logic [TW-1:0] first_t;
  logic [TW-1:0] last_t;

  assign t_w     = TW'(t);
  assign first_t = TW'(OFFSET + 1);
  assign last_t  = TW'(OFFSET) + TW'(k);

  assign en_mac    = gate && (t_w >= first_t) && (t_w <= last_t);
  assign clr_accum = gate && (t_w == first_t);

endmodule

// File: rtl/systolic_wave_seq.sv
// Wavefront sequencer for the NxN systolic MAC array: skewed RAM reads and per-PE MAC strobes.
// Optional perf counters are built when SYSTOLIC_SEQ_PERF_EN is defined.
module systolic_wave_seq
  import systolic_pkg::*;
#(
  parameter int N      = SEQ_N,
  parameter int ADDR_W = SEQ_ADDR_W,
  parameter int K_W    = SEQ_K_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [K_W-1:0]    k_len,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              hold,
  output logic [N-1:0]      ram_a_rden,
  output logic [N*ADDR_W-1:0] ram_a_addr,
  output logic [N-1:0]      ram_w_rden,
  output logic [N*ADDR_W-1:0] ram_w_addr,
  output logic [N*N-1:0]    en_mac,
  output logic [N*N-1:0]    clr_accum,
  output logic [15:0]       calc_cycles,
  output logic [15:0]       stall_cycles
);

  localparam int TW = K_W + 2;

  state_t         state;
  logic [K_W:0]   t;
  logic [K_W-1:0] k;
  logic           busy_q;
  logic           done_q;
  logic           gate;
  logic [TW-1:0]  t_w;
  logic [TW-1:0]  k_w;
  logic [TW-1:0]  last_t;

  assign t_w    = TW'(t);
  assign k_w    = TW'(k);
  assign last_t = k_w + TW'(2 * N - 2);
  assign gate   = (state == CALC) && !stall;
  assign hold   = (state == CALC) && stall;
  assign busy   = busy_q;
  assign done   = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      t      <= '0;
      k      <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            t      <= '0;
            if (k_len != '0) begin
              k     <= k_len;
              state <= CALC;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        CALC: begin
          if (!stall) begin
            t <= t + (K_W + 1)'(1);
            if (t_w == last_t) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Row i and column j share the same read window, skewed by their index.
  always_comb begin
    ram_a_rden = '0;
    ram_a_addr = '0;
    ram_w_rden = '0;
    ram_w_addr = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gate && (t_w >= TW'(i)) && (t_w < TW'(i) + k_w)) begin
        ram_a_rden[i]                 = 1'b1;
        ram_w_rden[i]                 = 1'b1;
        ram_a_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(t_w - TW'(i));
        ram_w_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(t_w - TW'(i));
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_wave_cell #(
        .K_W    (K_W),
        .OFFSET (i + j)
      ) u_cell (
        .t         (t),
        .k         (k),
        .gate      (gate),
        .en_mac    (en_mac[i*N+j]),
        .clr_accum (clr_accum[i*N+j])
      );
    end
  end

`ifdef SYSTOLIC_SEQ_PERF_EN
  logic [15:0] calc_q;
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      calc_q  <= '0;
      stall_q <= '0;
    end else if ((state == IDLE) && start) begin
      calc_q  <= '0;
      stall_q <= '0;
    end else if (state == CALC) begin
      if (stall) begin
        if (stall_q != '1) stall_q <= stall_q + 16'd1;
      end else begin
        if (calc_q != '1) calc_q <= calc_q + 16'd1;
      end
    end
  end

  assign calc_cycles  = calc_q;
  assign stall_cycles = stall_q;
`else
  assign calc_cycles  = '0;
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_wave_seq.sv
// Directed self-checking bench for systolic_wave_seq (N=2, ADDR_W=8, K_W=9).
module tb_systolic_wave_seq;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int KW = 9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            stall;
  logic            busy;
  logic            done;
  logic            hold;
  logic [N-1:0]    a_rden;
  logic [N*AW-1:0] a_addr;
  logic [N-1:0]    w_rden;
  logic [N*AW-1:0] w_addr;
  logic [N*N-1:0]  en_mac;
  logic [N*N-1:0]  clr_accum;
  logic [15:0]     calc_cycles;
  logic [15:0]     stall_cycles;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  systolic_wave_seq #(
    .N      (N),
    .ADDR_W (AW),
    .K_W    (KW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .k_len        (k_len),
    .stall        (stall),
    .busy         (busy),
    .done         (done),
    .hold         (hold),
    .ram_a_rden   (a_rden),
    .ram_a_addr   (a_addr),
    .ram_w_rden   (w_rden),
    .ram_w_addr   (w_addr),
    .en_mac       (en_mac),
    .clr_accum    (clr_accum),
    .calc_cycles  (calc_cycles),
    .stall_cycles (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Start accepted at the end of cycle 0; returns sitting in cycle 1.
  task automatic begin_pass(input int k);
    start = 1'b1;
    k_len = KW'(k);
    cyc   = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    while (!done && cyc < 600) step();
    chk(tag, cyc, exp_cyc);
    chk({tag, "_pulse"}, done, 1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rden"}, {a_rden, w_rden}, 0);
    chk({tag, "_addr"}, {a_addr, w_addr}, 0);
    chk({tag, "_mac"}, {en_mac, clr_accum}, 0);
    chk({tag, "_ctl"}, {busy, done, hold}, 0);
  endtask

  // Hand-derived strobe tables for N=2, K=4, indexed by t.
  int e_rd  [7] = '{1, 3, 3, 3, 2, 0, 0};
  int e_ad  [7] = '{'h0000, 'h0001, 'h0102, 'h0203, 'h0300, 0, 0};
  int e_en  [7] = '{0, 1, 7, 15, 15, 14, 8};
  int e_clr [7] = '{0, 1, 6, 8, 0, 0, 0};

  initial begin
    int ndone;
    int first_done;
    int max_a;
    int max_w;

    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    k_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    chk("reset_perf", {calc_cycles, stall_cycles}, 0);
    rst_n = 1'b1;
    step();
    chk_quiet("idle");

    // K=4, no stall
    begin_pass(4);
    for (int t = 0; t < 7; t++) begin
      chk($sformatf("k4_a_rden_t%0d", t), a_rden, e_rd[t]);
      chk($sformatf("k4_w_rden_t%0d", t), w_rden, e_rd[t]);
      chk($sformatf("k4_a_addr_t%0d", t), a_addr, e_ad[t]);
      chk($sformatf("k4_w_addr_t%0d", t), w_addr, e_ad[t]);
      chk($sformatf("k4_en_t%0d", t), en_mac, e_en[t]);
      chk($sformatf("k4_clr_t%0d", t), clr_accum, e_clr[t]);
      chk($sformatf("k4_ctl_t%0d", t), {busy, done, hold}, 3'b100);
      step();
    end
    chk("k4_done_cyc", cyc, 8);
    chk("k4_done", {busy, done}, 2'b11);
    step();
    chk("k4_after", {busy, done}, 2'b00);

    // K=4, stall high at t=2 for 3 cycles
    begin_pass(4);
    step();
    step();
    stall = 1'b1;
    #1;
    chk("st_rden", {a_rden, w_rden}, 0);
    chk("st_mac", {en_mac, clr_accum}, 0);
    chk("st_hold", {busy, hold}, 2'b11);
    step();
    chk("st_hold2", hold, 1);
    chk("st_mac2", en_mac, 0);
    step();
    step();
    stall = 1'b0;
    #1;
    chk("st_resume_rden", a_rden, 3);
    chk("st_resume_addr", a_addr, 'h0102);
    chk("st_resume_en", en_mac, 7);
    chk("st_resume_hold", hold, 0);
    wait_done("st_done", 11);
    step();

    // k_len=0, start held into DONE must be ignored
    start = 1'b1;
    k_len = '0;
    cyc   = 0;
    step();
    chk("k0_done", {busy, done}, 2'b11);
    chk("k0_strobes", {a_rden, w_rden, en_mac}, 0);
    step();
    start = 1'b0;
    chk("k0_after", {busy, done}, 2'b00);
    step();
    chk("k0_idle", busy, 0);

    // start pulsed while busy is dropped
    begin_pass(4);
    step();
    start = 1'b1;
    k_len = KW'(7);
    step();
    start = 1'b0;
    ndone      = 0;
    first_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = cyc;
      end
      step();
    end
    chk("busy_start_ndone", ndone, 1);
    chk("busy_start_cyc", first_done, 8);

    // reset mid-CALC at t=3
    begin_pass(4);
    step();
    step();
    step();
    chk("rst_pre_en", en_mac, 15);
    rst_n = 1'b0;
    step();
    chk_quiet("rst_mid");
    rst_n = 1'b1;
    step();
    chk_quiet("rst_idle");
    begin_pass(1);
    wait_done("k1_done", 5);
    step();

    // K=256 with 5 stall cycles
    begin_pass(256);
    max_a = 0;
    max_w = 0;
    while (!done && cyc < 600) begin
      stall = (cyc == 10 || cyc == 50 || cyc == 51 || cyc == 100 || cyc == 200);
      #1;
      for (int i = 0; i < N; i++) begin
        if (a_rden[i] && int'(a_addr[i*AW +: AW]) > max_a) max_a = int'(a_addr[i*AW +: AW]);
        if (w_rden[i] && int'(w_addr[i*AW +: AW]) > max_w) max_w = int'(w_addr[i*AW +: AW]);
      end
      step();
    end
    stall = 1'b0;
    chk("k256_done_cyc", cyc, 265);
    chk("k256_max_a", max_a, 255);
    chk("k256_max_w", max_w, 255);
`ifdef SYSTOLIC_SEQ_PERF_EN
    chk("perf_calc", calc_cycles, 259);
    chk("perf_stall", stall_cycles, 5);
    step();
    chk("perf_calc_hold", calc_cycles, 259);
    chk("perf_stall_hold", stall_cycles, 5);
`else
    chk("perf_calc_tied", calc_cycles, 0);
    chk("perf_stall_tied", stall_cycles, 0);
    step();
`endif
    begin_pass(1);
    chk("perf_clear", {calc_cycles, stall_cycles}, 0);
    wait_done("k1b_done", 5);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
